// File: rtl/mips_register_file_if.sv
// ============================================================================
//  Module      : mips_register_file_if
//  Description : Bundle of the register-file read/write/debug signals shared
//                between the datapath (master) and the register file (slave).
//                Port summary:
//                  ReadRegister1/2 : rs/rt read indices        (master -> slave)
//                  WriteRegister   : destination index         (master -> slave)
//                  WriteData       : writeback value           (master -> slave)
//                  RegWrite        : write enable, active high (master -> slave)
//                  DebugAddr       : third read index          (master -> slave)
//                  ReadData1/2     : rs/rt operands            (slave -> master)
//                  DebugData       : contents of DebugAddr     (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] ReadRegister1;
    logic [ADDR_WIDTH-1:0] ReadRegister2;
    logic [ADDR_WIDTH-1:0] WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] DebugAddr;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;
    logic [DATA_WIDTH-1:0] DebugData;

    // Datapath side: drives indices and writeback, consumes operands.
    modport master (
        output ReadRegister1,
        output ReadRegister2,
        output WriteRegister,
        output WriteData,
        output RegWrite,
        output DebugAddr,
        input  ReadData1,
        input  ReadData2,
        input  DebugData
    );

    // Register-file side.
    modport slave (
        input  ReadRegister1,
        input  ReadRegister2,
        input  WriteRegister,
        input  WriteData,
        input  RegWrite,
        input  DebugAddr,
        output ReadData1,
        output ReadData2,
        output DebugData
    );
endinterface

`default_nettype wire

// File: rtl/mips_register_file.sv
// ============================================================================
//  Module      : mips_register_file
//  Description : 32-entry (2**ADDR_WIDTH) general-purpose register file for
//                the single-cycle MIPS datapath. Two operand read ports
//                (rs, rt), one debug read port and one writeback port.
//                Register 0 is hardwired to zero; register 29 ($sp) resets
//                to SP_RESET, every other entry resets to zero.
//
//  Ports       : Clk  - system clock, writes on rising edge
//                Rst  - asynchronous, active-low reset
//                rf   - mips_register_file_if.slave carrying
//                       ReadRegister1/2, WriteRegister, WriteData, RegWrite,
//                       DebugAddr (in) and ReadData1/2, DebugData (out)
//
//  Build macro : REGFILE_BYPASS_EN
//                  defined   - write-through bypass: a read whose index
//                              matches an active, non-zero write index
//                              returns WriteData in the same cycle.
//                  undefined - reads reflect array contents only; a write is
//                              visible after its clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_register_file #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = '0
) (
    input  wire logic          Clk,
    input  wire logic          Rst,
    mips_register_file_if.slave rf
);

    localparam int c_num_regs  = 2 ** ADDR_WIDTH;
    localparam int c_sp_index  = 29;
    localparam int c_num_ports = 3;

    // ------------------------------------------------------------------------
    // Storage view: entry 0 is a constant zero, entries 1..N-1 are flops.
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_array [c_num_regs];

    assign w_array[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < c_num_regs; gi++) begin : g_entry
            localparam logic [DATA_WIDTH-1:0] c_reset_value =
                (gi == c_sp_index) ? SP_RESET : '0;

            logic [DATA_WIDTH-1:0] r_value;
            logic                  w_write_hit;

            assign w_write_hit = rf.RegWrite &&
                                 (rf.WriteRegister == ADDR_WIDTH'(gi));

            // The reset branch wins on the same edge Rst is still low, so a
            // clock edge coinciding with reset release never writes.
            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) begin
                    r_value <= c_reset_value;
                end else if (w_write_hit) begin
                    r_value <= rf.WriteData;
                end
            end

            assign w_array[gi] = r_value;
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    // Forwarding qualifier. Excluding index 0 keeps $zero reading zero on
    // every port, and gating with Rst keeps reset-time reads at reset values.
    logic w_bypass_valid;

    assign w_bypass_valid = rf.RegWrite && Rst && (rf.WriteRegister != '0);
`endif

    // ------------------------------------------------------------------------
    // Read ports: 0 = rs, 1 = rt, 2 = debug. All combinational.
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_raddr [c_num_ports];

    assign w_raddr[0] = rf.ReadRegister1;
    assign w_raddr[1] = rf.ReadRegister2;
    assign w_raddr[2] = rf.DebugAddr;

    genvar gp;
    generate
        for (gp = 0; gp < c_num_ports; gp++) begin : g_read_port
            logic [DATA_WIDTH-1:0] w_data;

            always_comb begin
                w_data = w_array[w_raddr[gp]];
`ifdef REGFILE_BYPASS_EN
                if (w_bypass_valid && (w_raddr[gp] == rf.WriteRegister)) begin
                    w_data = rf.WriteData;
                end
`endif
            end
        end
    endgenerate

    assign rf.ReadData1 = g_read_port[0].w_data;
    assign rf.ReadData2 = g_read_port[1].w_data;
    assign rf.DebugData = g_read_port[2].w_data;

endmodule

`default_nettype wire

// File: tb/tb_mips_register_file.sv
// ============================================================================
//  Module      : tb_mips_register_file
//  Description : Self-checking bench for mips_register_file. A plain array
//                models the architectural register state; expected read
//                values follow the register-file rules ($zero, reset values,
//                optional same-cycle forwarding).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mips_register_file;

    localparam logic [31:0] SP_RESET = 32'h0000_3FFC;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    logic [31:0] model [32];

    mips_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_bus ();

    mips_register_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .SP_RESET  (SP_RESET)
    ) dut (
        .Clk(clk),
        .Rst(rst_n),
        .rf (rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model[29] = SP_RESET;
    endtask

    // Value a read port must show for index a under the current bus inputs.
    function automatic logic [31:0] expect_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (BYPASS && rst_n && rf_bus.RegWrite && rf_bus.WriteRegister == a)
            return rf_bus.WriteData;
        return model[a];
    endfunction

    // Advance one clock: apply the edge to the model, then settle mid-cycle.
    task automatic step();
        @(posedge clk);
        if (rst_n && rf_bus.RegWrite && rf_bus.WriteRegister != 5'd0)
            model[rf_bus.WriteRegister] = rf_bus.WriteData;
        #2;
    endtask

    task automatic set_write(input logic we, input logic [4:0] wr, input logic [31:0] wd);
        rf_bus.RegWrite      = we;
        rf_bus.WriteRegister = wr;
        rf_bus.WriteData     = wd;
    endtask

    task automatic set_read(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        rf_bus.ReadRegister1 = a1;
        rf_bus.ReadRegister2 = a2;
        rf_bus.DebugAddr     = ad;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] exp_v;
        rst_n = 1'b0;
        model_reset();
        set_write(1'b1, 5'd5, 32'h1234_5678);
        set_read(5'd29, 5'd5, 5'd0);
        repeat (3) step();
        for (int i = 0; i < 32; i++) begin
            rf_bus.DebugAddr = 5'(i);
            #1;
            exp_v = (i == 29) ? SP_RESET : 32'h0;
            vectors++;
            if (rf_bus.DebugData !== exp_v) begin
                miscompares++;
                $display("FAIL reset_sweep idx=%0d got=%h exp=%h", i, rf_bus.DebugData, exp_v);
            end
        end
        vectors++;
        if (rf_bus.ReadData1 !== SP_RESET) begin
            miscompares++;
            $display("FAIL reset_sp_rd1 got=%h exp=%h", rf_bus.ReadData1, SP_RESET);
        end
        vectors++;
        if (rf_bus.ReadData2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_write_blocked got=%h exp=%h", rf_bus.ReadData2, 32'h0);
        end
        set_write(1'b0, 5'd0, 32'h0);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        set_write(1'b1, 5'd8, 32'hDEAD_BEEF);
        step();
        set_write(1'b0, 5'd8, 32'h0000_0001);
        set_read(5'd8, 5'd8, 5'd8);
        #1;
        vectors++;
        if (rf_bus.ReadData1 !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL basic_rd1 got=%h exp=%h", rf_bus.ReadData1, 32'hDEAD_BEEF);
        end
        vectors++;
        if (rf_bus.ReadData2 !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL basic_rd2 got=%h exp=%h", rf_bus.ReadData2, 32'hDEAD_BEEF);
        end
        step();
        vectors++;
        if (rf_bus.DebugData !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL basic_no_write got=%h exp=%h", rf_bus.DebugData, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_zero();
        set_write(1'b1, 5'd0, 32'hFFFF_FFFF);
        set_read(5'd0, 5'd0, 5'd0);
        #1;
        vectors++;
        if (rf_bus.ReadData1 !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_same_cycle got=%h exp=%h", rf_bus.ReadData1, 32'h0);
        end
        step();
        set_write(1'b0, 5'd0, 32'h0);
        #1;
        vectors++;
        if (rf_bus.ReadData1 !== 32'h0 || rf_bus.DebugData !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_after_edge got=%h/%h exp=%h", rf_bus.ReadData1, rf_bus.DebugData, 32'h0);
        end
    endtask

    task automatic test_link();
        logic [31:0] exp30;
        logic [31:0] exp1;
        exp30 = model[30];
        exp1  = model[1];
        set_write(1'b1, 5'd31, 32'h0040_0008);
        step();
        set_write(1'b0, 5'd0, 32'h0);
        set_read(5'd30, 5'd31, 5'd1);
        #1;
        vectors++;
        if (rf_bus.ReadData2 !== 32'h0040_0008) begin
            miscompares++;
            $display("FAIL link_r31 got=%h exp=%h", rf_bus.ReadData2, 32'h0040_0008);
        end
        vectors++;
        if (rf_bus.ReadData1 !== exp30 || rf_bus.DebugData !== exp1) begin
            miscompares++;
            $display("FAIL link_neighbours got=%h/%h exp=%h/%h",
                     rf_bus.ReadData1, rf_bus.DebugData, exp30, exp1);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_v;
        set_write(1'b1, 5'd9, 32'h0000_0005);
        step();
        set_write(1'b1, 5'd9, 32'h0000_000A);
        set_read(5'd9, 5'd9, 5'd9);
        #1;
        exp_v = BYPASS ? 32'h0000_000A : 32'h0000_0005;
        vectors++;
        if (rf_bus.ReadData1 !== exp_v || rf_bus.ReadData2 !== exp_v || rf_bus.DebugData !== exp_v) begin
            miscompares++;
            $display("FAIL same_cycle_pre got=%h/%h/%h exp=%h",
                     rf_bus.ReadData1, rf_bus.ReadData2, rf_bus.DebugData, exp_v);
        end
        step();
        set_write(1'b0, 5'd0, 32'h0);
        #1;
        vectors++;
        if (rf_bus.ReadData1 !== 32'h0000_000A) begin
            miscompares++;
            $display("FAIL same_cycle_post got=%h exp=%h", rf_bus.ReadData1, 32'h0000_000A);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] exp_v;
        for (int i = 1; i < 32; i++) begin
            set_write(1'b1, 5'(i), 32'(i) * 32'h0101_0101);
            step();
        end
        set_write(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            set_read(5'(i), 5'(31 - i), 5'(i));
            #1;
            exp_v = 32'(i) * 32'h0101_0101;
            vectors++;
            if (rf_bus.ReadData1 !== exp_v || rf_bus.DebugData !== exp_v) begin
                miscompares++;
                $display("FAIL sweep_p1_dbg idx=%0d got=%h/%h exp=%h",
                         i, rf_bus.ReadData1, rf_bus.DebugData, exp_v);
            end
            exp_v = 32'(31 - i) * 32'h0101_0101;
            vectors++;
            if (rf_bus.ReadData2 !== exp_v) begin
                miscompares++;
                $display("FAIL sweep_p2 idx=%0d got=%h exp=%h", 31 - i, rf_bus.ReadData2, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0]  wr;
        logic [31:0] e1, e2, ed;
        for (int n = 0; n < 400; n++) begin
            wr = 5'($urandom_range(0, 31));
            set_write(1'($urandom_range(0, 1)), wr, $urandom);
            set_read(($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
                     ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
                     ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)));
            #1;
            e1 = expect_read(rf_bus.ReadRegister1);
            e2 = expect_read(rf_bus.ReadRegister2);
            ed = expect_read(rf_bus.DebugAddr);
            vectors++;
            if (rf_bus.ReadData1 !== e1 || rf_bus.ReadData2 !== e2 || rf_bus.DebugData !== ed) begin
                miscompares++;
                $display("FAIL random n=%0d got=%h/%h/%h exp=%h/%h/%h",
                         n, rf_bus.ReadData1, rf_bus.ReadData2, rf_bus.DebugData, e1, e2, ed);
            end
            step();
        end
        set_write(1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_async_reset();
        logic [31:0] exp_v;
        set_write(1'b1, 5'd3, 32'hCAFE_0003);
        step();
        set_write(1'b1, 5'd29, 32'h7FFF_FFF0);
        step();
        set_write(1'b0, 5'd0, 32'h0);
        set_read(5'd3, 5'd29, 5'd9);
        #1;
        // Reset asserted mid-cycle; outputs must clear before the next edge.
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (rf_bus.ReadData1 !== 32'h0 || rf_bus.ReadData2 !== SP_RESET || rf_bus.DebugData !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset got=%h/%h/%h exp=%h/%h/%h",
                     rf_bus.ReadData1, rf_bus.ReadData2, rf_bus.DebugData, 32'h0, SP_RESET, 32'h0);
        end
        set_write(1'b1, 5'd3, 32'h1111_1111);
        step();
        vectors++;
        if (rf_bus.ReadData1 !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset_block got=%h exp=%h", rf_bus.ReadData1, 32'h0);
        end
        for (int i = 0; i < 32; i++) begin
            rf_bus.DebugAddr = 5'(i);
            #0.1;
            exp_v = (i == 29) ? SP_RESET : 32'h0;
            vectors++;
            if (rf_bus.DebugData !== exp_v) begin
                miscompares++;
                $display("FAIL async_reset_sweep idx=%0d got=%h exp=%h", i, rf_bus.DebugData, exp_v);
            end
        end
        set_write(1'b0, 5'd0, 32'h0);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        set_write(1'b0, 5'd0, 32'h0);
        set_read(5'd0, 5'd0, 5'd0);

        test_reset();
        test_basic();
        test_zero();
        test_link();
        test_same_cycle();
        test_sweep();
        test_random();
        test_async_reset();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_register_file.md
Name: mips_register_file

Overview:
- 32-entry general-purpose register file for the single-cycle MIPS datapath.
- Sits directly downstream of the write-register select mux: that mux picks rt/rd or forces register 31 for jal link writes, and its 5-bit output drives WriteRegister here.
- Supplies the two source operands (rs, rt) to the ALU-input stage.
- Performs the single per-cycle writeback, including the PC+4 link write into $31.

Parameters:
- DATA_WIDTH, 32, width of each register and data port.
- ADDR_WIDTH, 5, register index width; entry count = 2**ADDR_WIDTH.
- SP_RESET, 32'h0000_0000, value loaded into register 29 ($sp) on reset.

Ports:
- Clk  input  1  system clock; all writes on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- ReadRegister1  input  ADDR_WIDTH  rs index for port 1.
- ReadRegister2  input  ADDR_WIDTH  rt index for port 2.
- WriteRegister  input  ADDR_WIDTH  destination index (from the 31-select mux).
- WriteData  input  DATA_WIDTH  writeback value (ALU result, load data or PC+4).
- RegWrite  input  1  write enable, active high.
- ReadData1  output  DATA_WIDTH  contents of ReadRegister1.
- ReadData2  output  DATA_WIDTH  contents of ReadRegister2.
- DebugAddr  input  ADDR_WIDTH  third read index for bench/display.
- DebugData  output  DATA_WIDTH  contents of DebugAddr.

Behaviour:
- Storage: array of 2**ADDR_WIDTH registers, each DATA_WIDTH bits.
- Reset:
  - Rst low clears every register to 0 immediately, without waiting for Clk. The exception is register 29, which loads SP_RESET.
  - While Rst is low, writes are blocked.
  - Read outputs follow the array, so they read 0 (or SP_RESET for index 29) during reset.
  - Rst deasserting on a rising edge performs no write on that edge.
- Write:
  - On rising Clk edge with Rst high and RegWrite=1, reg[WriteRegister] <= WriteData.
  - RegWrite=0: no state change, whatever WriteRegister and WriteData are.
- Register 0:
  - Hardwired zero; a write to index 0 is discarded.
  - All read ports return 0 for index 0 in all cases, including bypass.
- Reads:
  - ReadData1, ReadData2 and DebugData are combinational functions of their address and the array.
  - Zero-cycle latency from address change.
  - A write becomes visible on the read ports after the write edge (base build).
- Simultaneous cases:
  - Both read ports may address the same register; both return the same value.
  - Reading and writing the same register in one cycle returns the old value until the edge (base build).
- Width: no arithmetic; no sign or zero extension; data passes bit-exact.
- Out-of-range indices are impossible (full ADDR_WIDTH decode).
- No X propagation after reset: every entry has a defined reset value.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass.
  - When RegWrite=1, Rst high, WriteRegister≠0 and a read address equals WriteRegister, that read port outputs WriteData combinationally in the same cycle.
  - Applies to ReadData1, ReadData2 and DebugData independently.
  - The array write still occurs at the edge.
- Not defined: no bypass; reads always reflect array contents only.

Test Plan:
- Reset: SP_RESET=32'h0000_3FFC. Hold Rst=0, sweep DebugAddr 0..31 -> 32'h0000_3FFC at index 29, 0 everywhere else. Pulse Rst low mid-run after writes -> array clears without a clock edge.
- Basic write/read: RegWrite=1, WriteRegister=8, WriteData=32'hDEAD_BEEF for one edge. Then ReadRegister1=8, ReadRegister2=8 -> both ReadData = 32'hDEAD_BEEF. RegWrite=0 with WriteData=32'h1 -> reg 8 unchanged.
- $zero: write 32'hFFFF_FFFF to index 0 -> ReadData1 (index 0) = 0, with or without REGFILE_BYPASS_EN.
- Link write: WriteRegister=31 (mux sel=1 case), WriteData=32'h0040_0008 -> ReadData2 (index 31) = 32'h0040_0008. Registers 30 and 1 unchanged.
- Same-cycle read/write: reg 9 = 32'h5, then in one cycle write 32'hA to 9 while reading 9 -> 32'h5 before the edge without the macro, 32'hA with REGFILE_BYPASS_EN. Both builds show 32'hA after the edge.
- Full sweep: write index i with value i*32'h0101_0101 for i=1..31, then read all indices via ports 1, 2 and Debug -> every value exact, index 0 = 0.
